conn_table_arbiter: RTL and testbench

- Shares the single connection-table searcher between two requesters: requester 0 is the RX header-parser path and requester 1 is the host command path.
- Arbitrates round-robin between the two and captures the winning request.
- Sequences the searcher interface: drives the connection tuple stable for a setup window before raising the request code, waits for done or timeout, then routes ID/error back to the granted requester.

---
 rtl/conn_table_arbiter_if.sv | 45 ++++
 rtl/conn_table_arbiter.sv | 157 +++++++++++++++
 tb/tb_conn_table_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/conn_table_arbiter_if.sv
// Handshake bundle between the two requesters, the arbiter and the connection-table searcher.
interface conn_table_arbiter_if #(
  parameter int TW = 144
);
  logic          req0_valid, req0_ready;
  logic [1:0]    req0_op;
  logic [7:0]    req0_id;
  logic [TW-1:0] req0_tuple;
  logic          req1_valid, req1_ready;
  logic [1:0]    req1_op;
  logic [7:0]    req1_id;
  logic [TW-1:0] req1_tuple;

  logic          rsp0_valid, rsp1_valid;
  logic [7:0]    rsp0_id, rsp0_error, rsp1_id, rsp1_error;

  logic [1:0]    rs_rq;
  logic [7:0]    rs_id_in;
  logic [31:0]   rs_ip_src, rs_ip_dst;
  logic [23:0]   rs_mac_src, rs_mac_dst;
  logic [15:0]   rs_port_src, rs_port_dst;
  logic          rs_done;
  logic [7:0]    rs_error, rs_id_out;

  // master: requesters plus searcher model; slave: the arbiter
  modport master (
    output req0_valid, req0_op, req0_id, req0_tuple,
    output req1_valid, req1_op, req1_id, req1_tuple,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_id, rsp0_error, rsp1_valid, rsp1_id, rsp1_error,
    input  rs_rq, rs_id_in, rs_ip_src, rs_ip_dst, rs_mac_src, rs_mac_dst,
    input  rs_port_src, rs_port_dst,
    output rs_done, rs_error, rs_id_out
  );

  modport slave (
    input  req0_valid, req0_op, req0_id, req0_tuple,
    input  req1_valid, req1_op, req1_id, req1_tuple,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_id, rsp0_error, rsp1_valid, rsp1_id, rsp1_error,
    output rs_rq, rs_id_in, rs_ip_src, rs_ip_dst, rs_mac_src, rs_mac_dst,
    output rs_port_src, rs_port_dst,
    input  rs_done, rs_error, rs_id_out
  );
endinterface

// File: rtl/conn_table_arbiter.sv
// Round-robin share of one connection-table searcher between RX parser (0) and host (1);
// sequences setup/issue/wait on the searcher and routes the result back.
module conn_table_arbiter #(
  parameter int SETUP_CYC = 2,
  parameter int TIMEOUT   = 64,
  parameter int TW        = 144
) (
  input  logic                 ca_clk,
  input  logic                 ca_rst,
  conn_table_arbiter_if.slave  ca,
  output logic                 ca_busy,
  output logic [7:0]           ca_timeout_cnt
);
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d, stall_q, stall_d;
  logic            last_q, cur_q;
  logic [1:0]      op_q;
  logic [7:0]      id_q;
  logic [TW-1:0]   tup_q;
  logic [1:0][7:0] rsp_id_q, rsp_err_q;
  logic [7:0]      tmo_q;

  logic            gnt_vld, gnt;
  logic [1:0]      gnt_op;
  logic [7:0]      gnt_id;
  logic [TW-1:0]   gnt_tup;
  logic            fin, fin_who, tmo_inc;
  logic [7:0]      fin_id, fin_err;

  // Requester 1 wins only if alone or requester 0 was served last.
  always_comb begin
    gnt_vld = ca.req0_valid | ca.req1_valid;
    gnt     = ca.req1_valid & (~ca.req0_valid | ~last_q);
    gnt_op  = gnt ? ca.req1_op    : ca.req0_op;
    gnt_id  = gnt ? ca.req1_id    : ca.req0_id;
    gnt_tup = gnt ? ca.req1_tuple : ca.req0_tuple;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_d = stall_q;
    fin     = 1'b0;
    fin_id  = 8'h00;
    fin_err = 8'h00;
    tmo_inc = 1'b0;
    fin_who = (state_q == S_IDLE) ? gnt : cur_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          cnt_d   = '0;
          stall_d = '0;
          if (^gnt_op) begin
            state_d = S_SETUP;
          end else begin
            state_d = S_RESP;
            fin     = 1'b1;
            fin_err = 8'hFE;
          end
        end
      end
      S_SETUP: begin
        // A still-high done from the searcher holds off the setup count.
        if (ca.rs_done) begin
          stall_d = stall_q + 16'd1;
          if (stall_q == 16'(TIMEOUT - 1)) begin
            state_d = S_RESP;
            fin     = 1'b1;
            fin_err = 8'hFF;
            tmo_inc = 1'b1;
          end
        end else if (cnt_q == 16'(SETUP_CYC - 1)) begin
          state_d = S_ISSUE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (ca.rs_done) begin
          state_d = S_RESP;
          fin     = 1'b1;
          fin_id  = ca.rs_id_out;
          fin_err = ca.rs_error;
        end else if (cnt_q == 16'(TIMEOUT - 1)) begin
          state_d = S_RESP;
          fin     = 1'b1;
          fin_err = 8'hFF;
          tmo_inc = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ca_clk) begin
    if (ca_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      stall_q   <= '0;
      last_q    <= 1'b1;
      cur_q     <= 1'b0;
      op_q      <= 2'b00;
      id_q      <= 8'h00;
      tup_q     <= '0;
      rsp_id_q  <= '0;
      rsp_err_q <= '0;
      tmo_q     <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      if (state_q == S_IDLE && gnt_vld) begin
        last_q <= gnt;
        cur_q  <= gnt;
        op_q   <= gnt_op;
        id_q   <= gnt_id;
        tup_q  <= gnt_tup;
      end
      if (fin) begin
        rsp_id_q[fin_who]  <= fin_id;
        rsp_err_q[fin_who] <= fin_err;
      end
      if (tmo_inc && tmo_q != 8'hFF) tmo_q <= tmo_q + 8'd1;
    end
  end

  assign ca.req0_ready  = (state_q == S_IDLE) & ca.req0_valid & ~gnt;
  assign ca.req1_ready  = (state_q == S_IDLE) & gnt;
  assign ca.rsp0_valid  = (state_q == S_RESP) & ~cur_q;
  assign ca.rsp1_valid  = (state_q == S_RESP) &  cur_q;
  assign ca.rsp0_id     = rsp_id_q[0];
  assign ca.rsp0_error  = rsp_err_q[0];
  assign ca.rsp1_id     = rsp_id_q[1];
  assign ca.rsp1_error  = rsp_err_q[1];

  assign ca.rs_rq       = (state_q == S_ISSUE || state_q == S_WAIT) ? op_q : 2'b00;
  assign ca.rs_id_in    = id_q;
  assign ca.rs_mac_src  = tup_q[143:120];
  assign ca.rs_mac_dst  = tup_q[119:96];
  assign ca.rs_ip_src   = tup_q[95:64];
  assign ca.rs_ip_dst   = tup_q[63:32];
  assign ca.rs_port_src = tup_q[31:16];
  assign ca.rs_port_dst = tup_q[15:0];

  assign ca_busy        = (state_q != S_IDLE);
  assign ca_timeout_cnt = tmo_q;
endmodule

// File: tb/tb_conn_table_arbiter.sv
// Directed vector bench for conn_table_arbiter: table of single transactions plus
// contention, timeout and reset-in-WAIT sequences.
module tb_conn_table_arbiter;
  localparam int SETUP_CYC = 2;
  localparam int TIMEOUT   = 64;
  localparam int TW        = 144;

  logic       clk;
  logic       rst;
  logic       busy;
  logic [7:0] tmo_cnt;
  int         n_tests;
  int         n_fail;

  conn_table_arbiter_if #(.TW(TW)) bus ();

  conn_table_arbiter #(.SETUP_CYC(SETUP_CYC), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .ca_clk         (clk),
    .ca_rst         (rst),
    .ca             (bus),
    .ca_busy        (busy),
    .ca_timeout_cnt (tmo_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            who;
    logic [1:0]    op;
    logic [7:0]    id;
    logic [TW-1:0] tup;
    int            dly;   // cycles after rs_rq rises until done; -1 = never
    logic [7:0]    sid;
    logic [7:0]    serr;
    logic [7:0]    eid;
    logic [7:0]    eerr;
    int            erq;   // expected cycle of rs_rq rise after acceptance, -1 = never
    int            elat;  // expected response cycle after acceptance
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  function automatic logic [TW-1:0] rs_tuple();
    return {bus.rs_mac_src, bus.rs_mac_dst, bus.rs_ip_src, bus.rs_ip_dst,
            bus.rs_port_src, bus.rs_port_dst};
  endfunction

  task automatic drive_req(input int who, input logic v, input logic [1:0] op,
                           input logic [7:0] id, input logic [TW-1:0] tup);
    if (who == 0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_id = id; bus.req0_tuple = tup;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_id = id; bus.req1_tuple = tup;
    end
  endtask

  task automatic do_op(input vec_t v, input string tag);
    int         first_rq, rsp_cyc, other;
    logic       tup_bad, rdy, rv, ov;
    logic [1:0] rq_at, rq_rsp;
    logic [7:0] idin, rid, rerr;
    first_rq = -1; rsp_cyc = -1; other = 0; tup_bad = 1'b0;
    rq_at = 2'b00; rq_rsp = 2'b11; idin = 8'h00; rid = 8'h00; rerr = 8'h00;
    @(negedge clk);
    drive_req(v.who, 1'b1, v.op, v.id, v.tup);
    bus.rs_id_out = v.sid;
    bus.rs_error  = v.serr;
    #1;
    rdy = (v.who == 0) ? bus.req0_ready : bus.req1_ready;
    chk({tag, " ready"}, int'(rdy), 1);
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 1) drive_req(v.who, 1'b0, 2'b00, 8'h00, '0);
      if (bus.rs_rq != 2'b00 && first_rq < 0) begin
        first_rq = n; rq_at = bus.rs_rq; idin = bus.rs_id_in;
      end
      rv = (v.who == 0) ? bus.rsp0_valid : bus.rsp1_valid;
      ov = (v.who == 0) ? bus.rsp1_valid : bus.rsp0_valid;
      if (ov) other++;
      if (rv) begin
        rsp_cyc = n; rq_rsp = bus.rs_rq;
        rid  = (v.who == 0) ? bus.rsp0_id    : bus.rsp1_id;
        rerr = (v.who == 0) ? bus.rsp0_error : bus.rsp1_error;
        break;
      end
      if (v.erq >= 0 && rs_tuple() != v.tup) tup_bad = 1'b1;
      if (v.dly >= 0 && first_rq >= 0 && n == first_rq + v.dly) bus.rs_done = 1'b1;
    end
    bus.rs_done = 1'b0;
    chk({tag, " rq_cycle"}, first_rq, v.erq);
    if (v.erq >= 0) begin
      chk({tag, " rq_code"}, int'(rq_at), int'(v.op));
      chk({tag, " id_in"}, int'(idin), int'(v.id));
      chk({tag, " tuple_stable"}, int'(tup_bad), 0);
    end
    chk({tag, " rsp_cycle"}, rsp_cyc, v.elat);
    chk({tag, " rsp_id"}, int'(rid), int'(v.eid));
    chk({tag, " rsp_err"}, int'(rerr), int'(v.eerr));
    chk({tag, " rq_in_resp"}, int'(rq_rsp), 0);
    chk({tag, " other_rsp"}, other, 0);
  endtask

  logic [TW-1:0] t1, t2, t3;
  int            gseq[4];
  int            ng, nr0, nr1, nstrobe, seen_rq;
  logic          stop_pending;

  initial begin
    n_tests = 0; n_fail = 0;
    t1 = {24'hA1B2C3, 24'hD4E5F6, 32'hC0A80001, 32'h0A000002, 16'd1234, 16'd80};
    t2 = {24'h102030, 24'h405060, 32'h7F000001, 32'hFFFFFFFE, 16'hBEEF, 16'h0001};
    t3 = {24'hFFFFFF, 24'h000001, 32'h01020304, 32'h05060708, 16'h8000, 16'h7FFF};
    //        who op     id     tup dly sid    serr   eid    eerr   erq elat
    vt[0] = '{0, 2'b01, 8'h00, t1,  3, 8'h05, 8'h02, 8'h05, 8'h02,  3,  7};
    vt[1] = '{1, 2'b10, 8'h07, t2,  1, 8'h07, 8'h00, 8'h07, 8'h00,  3,  5};
    vt[2] = '{0, 2'b11, 8'h33, t3,  2, 8'h44, 8'h55, 8'h00, 8'hFE, -1,  1};
    vt[3] = '{1, 2'b00, 8'h12, t1,  2, 8'h44, 8'h55, 8'h00, 8'hFE, -1,  1};
    vt[4] = '{0, 2'b10, 8'h3C, t3,  5, 8'h3C, 8'h11, 8'h3C, 8'h11,  3,  9};
    vt[5] = '{0, 2'b01, 8'h00, t2, -1, 8'h66, 8'h77, 8'h00, 8'hFF,  3, 68};
    vt[6] = '{1, 2'b01, 8'h00, t3,  2, 8'h9A, 8'h00, 8'h9A, 8'h00,  3,  6};

    rst = 1'b1;
    drive_req(0, 1'b0, 2'b00, 8'h00, '0);
    drive_req(1, 1'b0, 2'b00, 8'h00, '0);
    bus.rs_done = 1'b0; bus.rs_error = 8'h00; bus.rs_id_out = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset rs_rq", int'(bus.rs_rq), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset rsp_valid", int'({bus.rsp0_valid, bus.rsp1_valid}), 0);
    chk("reset rsp0", int'({bus.rsp0_id, bus.rsp0_error}), 0);
    chk("reset rsp1", int'({bus.rsp1_id, bus.rsp1_error}), 0);
    chk("reset tmo_cnt", int'(tmo_cnt), 0);
    chk("reset rs_data", int'(rs_tuple() != '0), 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      do_op(vt[i], $sformatf("vec%0d", i));
      if (i == 5) chk("timeout_cnt", int'(tmo_cnt), 1);
    end

    // Both requesters held valid for four operations; last grant was requester 1.
    ng = 0; nr0 = 0; nr1 = 0; stop_pending = 1'b0;
    @(negedge clk);
    drive_req(0, 1'b1, 2'b01, 8'h01, t1);
    drive_req(1, 1'b1, 2'b01, 8'h02, t2);
    bus.rs_id_out = 8'h21; bus.rs_error = 8'h00;
    #1;
    for (int n = 0; n < 300 && (nr0 + nr1) < 4; n++) begin
      if (n > 0) @(negedge clk);
      if (stop_pending) begin
        drive_req(0, 1'b0, 2'b00, 8'h00, '0);
        drive_req(1, 1'b0, 2'b00, 8'h00, '0);
        #1;
      end
      if (bus.req0_ready && ng < 4) begin gseq[ng] = 0; ng++; end
      else if (bus.req1_ready && ng < 4) begin gseq[ng] = 1; ng++; end
      if (bus.rsp0_valid) nr0++;
      if (bus.rsp1_valid) nr1++;
      if (ng == 4) stop_pending = 1'b1;
      if (bus.rs_rq != 2'b00) bus.rs_done = 1'b1;
      else bus.rs_done = 1'b0;
    end
    bus.rs_done = 1'b0;
    chk("rr grants", ng, 4);
    for (int k = 0; k < 4; k++) chk($sformatf("rr grant%0d", k), gseq[k], k % 2);
    chk("rr rsp0 count", nr0, 2);
    chk("rr rsp1 count", nr1, 2);

    // Reset while the searcher is in WAIT; the request is re-issued afterwards.
    @(negedge clk);
    drive_req(0, 1'b1, 2'b01, 8'h00, t1);
    seen_rq = -1;
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      if (n == 1) drive_req(0, 1'b0, 2'b00, 8'h00, '0);
      if (bus.rs_rq != 2'b00) begin seen_rq = n; break; end
    end
    chk("rstwait rq_cycle", seen_rq, 3);
    repeat (2) @(negedge clk);
    chk("rstwait busy_before", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstwait rs_rq", int'(bus.rs_rq), 0);
    chk("rstwait busy", int'(busy), 0);
    chk("rstwait tmo_cnt", int'(tmo_cnt), 0);
    rst = 1'b0;
    nstrobe = int'(bus.rsp0_valid) + int'(bus.rsp1_valid);
    repeat (4) begin
      @(negedge clk);
      nstrobe += int'(bus.rsp0_valid) + int'(bus.rsp1_valid);
    end
    chk("rstwait no_rsp", nstrobe, 0);
    do_op(vt[0], "reissue");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
